ps2_rx: RTL and testbench

- PS/2 host-side receiver. Reads device-to-host frames from the Basys3 USB-HID PS/2 pins (PS2Clk/PS2Data) and delivers scan-code bytes to the SoC through a valid/ready interface.
- Runs entirely in the core clock domain. Both PS/2 lines are treated as asynchronous inputs and are synchronized and glitch-filtered internally.
- Intended consumer: a keyboard peripheral on the AXI4-Lite crossbar, or a directly-wired GPIO/FIFO.

---
 rtl/ps2_pkg.sv | 12 +
 rtl/ps2_clk_filter.sv | 40 ++++
 rtl/sync.sv | 23 ++
 rtl/ps2_rx.sv | 128 ++++++++++++
 tb/tb_ps2_rx.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and helpers for the PS/2 receiver
package ps2_pkg;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;

    localparam int PS2_DATA_BITS = 8;

    function automatic logic odd_parity(input logic [PS2_DATA_BITS-1:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// rtl/ps2_clk_filter.sv - debounces the synced PS/2 clock and strobes on its falling edge
module ps2_clk_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clk_sync,
    output logic clk_filt,
    output logic fall_strobe
);

    localparam int CNT_W = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic [CNT_W-1:0] cnt;

    // The filtered clock only follows the synced clock after it has differed
    // for FILTER_LEN consecutive cycles; any match in between restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            clk_filt    <= 1'b1;
            fall_strobe <= 1'b0;
        end else begin
            fall_strobe <= 1'b0;
            if (clk_sync != clk_filt) begin
                if (cnt == CNT_LAST) begin
                    cnt         <= '0;
                    clk_filt    <= clk_sync;
                    fall_strobe <= clk_filt;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/sync.sv
// rtl/sync.sv - two-flop synchronizer for an asynchronous input
module sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 device-to-host frame receiver with valid/ready byte output
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int CLK_FREQ   = 10_000_000,
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT_US = 2000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ps2_clk,
    input  logic                     ps2_data,
    output logic [PS2_DATA_BITS-1:0] rx_data,
    output logic                     rx_valid,
    input  logic                     rx_ready,
    output logic                     busy,
    output logic                     parity_err,
    output logic                     frame_err,
    output logic                     overflow
);

    localparam int TIMEOUT_CYCLES = CLK_FREQ / 1_000_000 * TIMEOUT_US;
    localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic clk_s;
    logic data_s;
    logic clk_filt;
    logic strobe;

    ps2_state_t               state;
    logic [2:0]               bitcnt;
    logic [PS2_DATA_BITS-1:0] shift;
    logic                     par;
    logic [TO_W-1:0]          to_cnt;

    sync #(.RESET_VAL(1'b1)) u_sync_clk (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ps2_clk),
        .q     (clk_s)
    );

    sync #(.RESET_VAL(1'b1)) u_sync_data (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ps2_data),
        .q     (data_s)
    );

    ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
        .clk         (clk),
        .rst_n       (rst_n),
        .clk_sync    (clk_s),
        .clk_filt    (clk_filt),
        .fall_strobe (strobe)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bitcnt     <= '0;
            shift      <= '0;
            par        <= 1'b0;
            to_cnt     <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;

            if (rx_valid && rx_ready)
                rx_valid <= 1'b0;

            if (state == IDLE || strobe)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + TO_W'(1);

            // A stalled device abandons the partial byte; the next start bit resyncs.
            if (state != IDLE && !strobe && to_cnt == TO_LAST) begin
                state     <= IDLE;
                frame_err <= 1'b1;
            end else if (strobe) begin
                case (state)
                    IDLE: begin
                        if (!data_s) begin
                            state  <= DATA;
                            bitcnt <= '0;
                        end
                    end
                    DATA: begin
                        shift <= {data_s, shift[PS2_DATA_BITS-1:1]};
                        if (bitcnt == 3'd7)
                            state <= PARITY;
                        else
                            bitcnt <= bitcnt + 3'd1;
                    end
                    PARITY: begin
                        par   <= data_s;
                        state <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (!data_s) begin
                            frame_err <= 1'b1;
                        end else if (odd_parity(shift) != par) begin
                            parity_err <= 1'b1;
                        end else if (!rx_valid || rx_ready) begin
                            rx_data  <= shift;
                            rx_valid <= 1'b1;
                        end else begin
                            overflow <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_rx.sv
// tb/tb_ps2_rx.sv - self-checking bench for ps2_rx with a byte scoreboard
module tb_ps2_rx;

    localparam int TIMEOUT_CYCLES = 2000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b1;
    logic       busy;
    logic       parity_err;
    logic       frame_err;
    logic       overflow;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int pe_cnt = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int acc_cnt = 0;
    int fe_cyc = 0;
    int fall_cyc = 0;
    logic [7:0] sb[$];

    ps2_rx #(
        .CLK_FREQ   (1_000_000),
        .FILTER_LEN (8),
        .TIMEOUT_US (2000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .busy       (busy),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (parity_err) pe_cnt++;
            if (frame_err) begin
                fe_cnt++;
                fe_cyc = cyc;
            end
            if (overflow) ov_cnt++;
            if (rx_valid && rx_ready) begin
                acc_cnt++;
                if (sb.size() == 0)
                    check("unexpected_byte", {24'd0, rx_data}, 32'hFFFF_FFFF);
                else
                    check("sb_byte", {24'd0, rx_data}, {24'd0, sb.pop_front()});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One PS/2 bit: data changes while the clock is high, then an 80-cycle clock period.
    task automatic drive_bit(input logic b, input logic glitch);
        ps2_data = b;
        tick(8);
        if (glitch) begin
            ps2_clk = 1'b0;
            tick(3);
            ps2_clk = 1'b1;
            tick(9);
        end else begin
            tick(12);
        end
        ps2_clk = 1'b0;
        fall_cyc = cyc;
        tick(40);
        ps2_clk = 1'b1;
        tick(20);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop_bit,
                              input int nbits, input logic glitch);
        logic [10:0] bits;
        bits = {stop_bit, (~^d) ^ par_flip, d, 1'b0};
        for (int i = 0; i < nbits; i++)
            drive_bit(bits[i], glitch && (i == 4));
        ps2_data = 1'b1;
        tick(30);
    endtask

    initial begin
        int pe0, fe0, ov0, acc0;
        int delay;

        tick(3);
        check("rst_rx_data", {24'd0, rx_data}, 32'h0);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'h0);
        check("rst_pulses", {29'd0, parity_err, frame_err, overflow}, 32'h0);
        rst_n = 1'b1;
        tick(5);

        // Clean 0x1C frame
        pe0 = pe_cnt; fe0 = fe_cnt; ov0 = ov_cnt; acc0 = acc_cnt;
        sb.push_back(8'h1C);
        send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
        check("t1_accepted", acc_cnt - acc0, 1);
        check("t1_rx_data", {24'd0, rx_data}, 32'h1C);
        check("t1_rx_valid_low", {31'd0, rx_valid}, 32'h0);
        check("t1_no_errors", (pe_cnt - pe0) + (fe_cnt - fe0) + (ov_cnt - ov0), 0);
        check("t1_busy", {31'd0, busy}, 32'h0);

        // Bad parity
        pe0 = pe_cnt; acc0 = acc_cnt;
        send_frame(8'h1C, 1'b1, 1'b1, 11, 1'b0);
        check("t2_parity_err", pe_cnt - pe0, 1);
        check("t2_no_accept", acc_cnt - acc0, 0);
        check("t2_rx_valid", {31'd0, rx_valid}, 32'h0);
        check("t2_rx_data", {24'd0, rx_data}, 32'h1C);

        // Start + 3 data bits, then the clock idles until timeout
        fe0 = fe_cnt;
        send_frame(8'h00, 1'b0, 1'b1, 4, 1'b0);
        check("t3_busy_mid", {31'd0, busy}, 32'h1);
        for (int i = 0; i < 2300 && fe_cnt == fe0; i++) tick(1);
        check("t3_frame_err", fe_cnt - fe0, 1);
        delay = fe_cyc - fall_cyc;
        check("t3_timeout_window",
              {31'd0, (delay >= TIMEOUT_CYCLES + 5) && (delay <= TIMEOUT_CYCLES + 15)}, 32'h1);
        check("t3_busy", {31'd0, busy}, 32'h0);
        acc0 = acc_cnt;
        sb.push_back(8'hF0);
        send_frame(8'hF0, 1'b0, 1'b1, 11, 1'b0);
        check("t3_accept_f0", acc_cnt - acc0, 1);
        check("t3_rx_data", {24'd0, rx_data}, 32'hF0);

        // Overflow with consumer stalled
        ov0 = ov_cnt; acc0 = acc_cnt;
        rx_ready = 1'b0;
        sb.push_back(8'h1C);
        send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b1, 11, 1'b0);
        check("t4_overflow", ov_cnt - ov0, 1);
        check("t4_rx_valid", {31'd0, rx_valid}, 32'h1);
        check("t4_rx_data_held", {24'd0, rx_data}, 32'h1C);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        tick(2);
        check("t4_accepted", acc_cnt - acc0, 1);
        check("t4_rx_valid_drop", {31'd0, rx_valid}, 32'h0);

        // Glitches while idle and mid-frame, then a bad stop bit
        ps2_data = 1'b0;
        ps2_clk = 1'b0;
        tick(3);
        ps2_clk = 1'b1;
        tick(20);
        ps2_data = 1'b1;
        check("t5_idle_glitch_busy", {31'd0, busy}, 32'h0);
        pe0 = pe_cnt; fe0 = fe_cnt; ov0 = ov_cnt;
        sb.push_back(8'hA5);
        send_frame(8'hA5, 1'b0, 1'b1, 11, 1'b1);
        check("t5_rx_valid", {31'd0, rx_valid}, 32'h1);
        check("t5_rx_data", {24'd0, rx_data}, 32'hA5);
        check("t5_no_errors", (pe_cnt - pe0) + (fe_cnt - fe0) + (ov_cnt - ov0), 0);
        send_frame(8'h3C, 1'b0, 1'b0, 11, 1'b0);
        check("t5_stop_frame_err", fe_cnt - fe0, 1);
        check("t5_rx_data_kept", {24'd0, rx_data}, 32'hA5);

        // Reset in the middle of a frame
        send_frame(8'hFF, 1'b0, 1'b1, 6, 1'b0);
        check("t6_busy_before", {31'd0, busy}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_rx_data", {24'd0, rx_data}, 32'h0);
        check("t6_rst_rx_valid", {31'd0, rx_valid}, 32'h0);
        check("t6_rst_busy", {31'd0, busy}, 32'h0);
        check("t6_rst_pulses", {29'd0, parity_err, frame_err, overflow}, 32'h0);
        sb.delete();
        rx_ready = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(3);
        acc0 = acc_cnt; pe0 = pe_cnt; fe0 = fe_cnt;
        sb.push_back(8'h5A);
        send_frame(8'h5A, 1'b0, 1'b1, 11, 1'b0);
        check("t6_accept_5a", acc_cnt - acc0, 1);
        check("t6_rx_data", {24'd0, rx_data}, 32'h5A);
        check("t6_no_errors", (pe_cnt - pe0) + (fe_cnt - fe0), 0);

        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
